// File: rtl/fpga_input_conditioner.sv
// Board input conditioner: per-channel synchroniser, polarity fix and debounce, plus a
// PLL-lock-qualified stretched reset. Edge pulse outputs are built only with INPUT_COND_EDGE_EN.
module fpga_input_conditioner #(
  parameter int unsigned         CHANNELS        = 8,
  parameter int unsigned         SYNC_STAGES     = 2,
  parameter int unsigned         DEBOUNCE_CYCLES = 126000,
  parameter logic [CHANNELS-1:0] INVERT_MASK     = '0,
  parameter int unsigned         RST_HOLD_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] pins_i,
  input  logic                pll_locked_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic                rst_n_o
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

  typedef enum logic {
    HOLD,
    RUN
  } rst_state_e;

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] pin_sync_q;
  logic [SYNC_STAGES-1:0]               lock_sync_q;
  logic [CHANNELS-1:0]                  s;
  logic                                 lk;

  logic [CHANNELS-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [CHANNELS-1:0]           level_q, level_d;

  rst_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pin_sync_q  <= '0;
      lock_sync_q <= '0;
    end else begin
      pin_sync_q  <= {pin_sync_q[SYNC_STAGES-2:0], pins_i ^ INVERT_MASK};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  assign s  = pin_sync_q[SYNC_STAGES-1];
  assign lk = lock_sync_q[SYNC_STAGES-1];

  // Counter tops out at DEBOUNCE_CYCLES-1: the accepting cycle clears it instead of incrementing.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (s[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = s[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q  <= '0;
      db_cnt_q <= '0;
    end else begin
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign level_o = level_q;

`ifdef INPUT_COND_EDGE_EN
  logic [CHANNELS-1:0] rise_q, fall_q;

  // Pulses are registered from the next-level value so they line up with level_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= level_d & ~level_q;
      fall_q <= ~level_d & level_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = '0;
  assign fall_o = '0;
`endif

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    case (state_q)
      HOLD: begin
        if (lk) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = RUN;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end
      RUN: begin
        if (!lk) begin
          state_d = HOLD;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign rst_n_o = (state_q == RUN);

endmodule

// File: tb/tb_fpga_input_conditioner.sv
// Self-checking bench for fpga_input_conditioner: directed sequences, a pulse table and
// randomized stimulus against a window/run-length reference model.
module tb_fpga_input_conditioner;

  localparam int unsigned   CH  = 4;
  localparam int unsigned   SS  = 2;
  localparam int unsigned   DB  = 8;
  localparam int unsigned   RH  = 16;
  localparam logic [CH-1:0] INV = 4'b0001;

`ifdef INPUT_COND_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] pins = '0;
  logic          locked = 1'b0;
  logic [CH-1:0] level, rise, fall;
  logic          rst_n;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  fpga_input_conditioner #(
    .CHANNELS(CH),
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DB),
    .INVERT_MASK(INV),
    .RST_HOLD_CYCLES(RH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pins_i(pins),
    .pll_locked_i(locked),
    .level_o(level),
    .rise_o(rise),
    .fall_o(fall),
    .rst_n_o(rst_n)
  );

  always #5 clk = ~clk;

  // Reference model: delay lines for the synchronisers, a window of the last DB synchronised
  // samples for debounce, and a run length of consecutive lock samples for the reset.
  logic [CH-1:0] s_dly[$];
  logic [CH-1:0] s_win[$];
  logic          lk_dly[$];
  logic [CH-1:0] m_level, m_rise, m_fall;
  logic          m_rstn;
  int unsigned   lk_run;

  task automatic model_reset();
    s_dly  = {};
    s_win  = {};
    lk_dly = {};
    repeat (SS) begin
      s_dly.push_back('0);
      lk_dly.push_back(1'b0);
    end
    repeat (DB) s_win.push_back('0);
    m_level = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_rstn  = 1'b0;
    lk_run  = 0;
  endtask

  task automatic model_edge();
    logic [CH-1:0] sv, nl;
    logic          lkv, all_diff;
    sv = s_dly.pop_front();
    s_dly.push_back(pins ^ INV);
    lkv = lk_dly.pop_front();
    lk_dly.push_back(locked);
    void'(s_win.pop_front());
    s_win.push_back(sv);
    nl = m_level;
    for (int c = 0; c < CH; c++) begin
      all_diff = 1'b1;
      foreach (s_win[k]) if (s_win[k][c] == m_level[c]) all_diff = 1'b0;
      if (all_diff) nl[c] = ~m_level[c];
    end
    m_rise  = nl & ~m_level;
    m_fall  = ~nl & m_level;
    m_level = nl;
    lk_run  = lkv ? lk_run + 1 : 0;
    m_rstn  = (lk_run >= RH);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    chk("model_level", 32'(level), 32'(m_level));
    chk("model_rise", 32'(rise), 32'(EDGE_EN ? m_rise : '0));
    chk("model_fall", 32'(fall), 32'(EDGE_EN ? m_fall : '0));
    chk("model_rst_n", 32'(rst_n), 32'(m_rstn));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  typedef struct {
    int ch;
    int len;
    int exp_up_at;
    int exp_dn_at;
  } pulse_vec_t;

  pulse_vec_t pv[6];

  initial begin
    int up_at, dn_at, n_rise, n_fall, ch;

    pv[0] = '{2, 7, -1, -1};
    pv[1] = '{2, 8, 10, 18};
    pv[2] = '{3, 1, -1, -1};
    pv[3] = '{1, 9, 10, 19};
    pv[4] = '{3, 12, 10, 22};
    pv[5] = '{1, 6, -1, -1};

    model_reset();

    // Reset held with all inputs active
    rst    = 1'b1;
    pins   = 4'hF;
    locked = 1'b1;
    repeat (3) begin
      step();
      chk("reset_level", 32'(level), 32'h0);
      chk("reset_edges", 32'(rise | fall), 32'h0);
      chk("reset_rst_n", 32'(rst_n), 32'h0);
    end

    // Inverted channel 0 rises 10 cycles after release with its pin low
    pins   = 4'h0;
    locked = 1'b0;
    step();
    rst = 1'b0;
    run(9);
    chk("inv_level_early", 32'(level[0]), 32'h0);
    step();
    chk("inv_level", 32'(level[0]), 32'h1);
    chk("inv_rise", 32'(rise[0]), 32'(EDGE_EN));

    // Clean step on channel 1
    pins[1] = 1'b1;
    run(9);
    chk("step_level_early", 32'(level[1]), 32'h0);
    step();
    chk("step_level", 32'(level[1]), 32'h1);
    chk("step_rise", 32'(rise[1]), 32'(EDGE_EN));
    step();
    chk("step_rise_one_cycle", 32'(rise[1]), 32'h0);
    pins[1] = 1'b0;
    run(9);
    chk("step_fall_early", 32'(level[1]), 32'h1);
    step();
    chk("step_fall_level", 32'(level[1]), 32'h0);
    chk("step_fall", 32'(fall[1]), 32'(EDGE_EN));

    // Pulse table: glitch rejection vs accepted pulses
    for (int v = 0; v < 6; v++) begin
      ch     = pv[v].ch;
      up_at  = -1;
      dn_at  = -1;
      n_rise = 0;
      n_fall = 0;
      pins[ch] = 1'b1;
      for (int t = 1; t <= 40; t++) begin
        step();
        if (t == pv[v].len) pins[ch] = 1'b0;
        if (level[ch] && up_at < 0) up_at = t;
        if (!level[ch] && up_at >= 0 && dn_at < 0) dn_at = t;
        n_rise += int'(rise[ch]);
        n_fall += int'(fall[ch]);
      end
      chk("pulse_up_at", 32'(up_at), 32'(pv[v].exp_up_at));
      chk("pulse_dn_at", 32'(dn_at), 32'(pv[v].exp_dn_at));
      chk("pulse_rises", 32'(n_rise), 32'((pv[v].exp_up_at >= 0 && EDGE_EN) ? 1 : 0));
      chk("pulse_falls", 32'(n_fall), 32'((pv[v].exp_dn_at >= 0 && EDGE_EN) ? 1 : 0));
    end

    // Reset release after lock
    locked = 1'b1;
    repeat (17) begin
      step();
      chk("lock_hold", 32'(rst_n), 32'h0);
    end
    step();
    chk("lock_release", 32'(rst_n), 32'h1);

    // Lock loss in RUN
    locked = 1'b0;
    run(2);
    chk("lock_loss_early", 32'(rst_n), 32'h1);
    step();
    chk("lock_loss", 32'(rst_n), 32'h0);
    locked = 1'b1;
    run(17);
    chk("relock_hold", 32'(rst_n), 32'h0);
    step();
    chk("relock_release", 32'(rst_n), 32'h1);

    // Dropout of 3 cycles with the hold count at 10
    locked = 1'b0;
    run(5);
    locked = 1'b1;
    run(12);
    locked = 1'b0;
    run(3);
    locked = 1'b1;
    repeat (17) begin
      step();
      chk("dropout_hold", 32'(rst_n), 32'h0);
    end
    step();
    chk("dropout_release", 32'(rst_n), 32'h1);

    // Asynchronous reset with channel 3 counter at 5
    pins[3] = 1'b1;
    run(7);
    chk("midrst_pre_level", 32'(level), 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_level", 32'(level), 32'h0);
    chk("midrst_edges", 32'(rise | fall), 32'h0);
    chk("midrst_rst_n", 32'(rst_n), 32'h0);
    model_reset();
    step();
    rst = 1'b0;
    run(9);
    chk("midrst_ch3_early", 32'(level[3]), 32'h0);
    step();
    chk("midrst_ch3", 32'(level[3]), 32'h1);

    // Randomized stimulus against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) pins[$urandom_range(0, CH - 1)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0 && $urandom_range(0, 1) == 0) pins = CH'($urandom);
      if ($urandom_range(0, 39) == 0) locked = ~locked;
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        #1;
        chk("rand_async_rst", 32'({level, rise, fall, rst_n}), 32'h0);
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
